// File: rtl/rv_imm_pkg.sv
// Immediate-format and opcode encodings shared by the immediate generator.
package rv_imm_pkg;

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
  localparam logic [2:0] FMT_Z    = 3'b101;
  localparam logic [2:0] FMT_SH   = 3'b110;
  localparam logic [2:0] FMT_NONE = 3'b111;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/imm_fmt_comb.sv
// Combinational immediate decode: picks the format (opcode or external select) and extends to XLEN.
// Zero latency, no handshake.
module imm_fmt_comb
  import rv_imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit AUTO_SRC = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [2:0]  auto_fmt;
  logic        reg_op;
  logic [2:0]  sel_fmt;
  logic        none_ok;
  logic [31:0] imm32;
  logic        sext;
  logic        field_bad;

  always_comb begin
    auto_fmt = FMT_NONE;
    reg_op   = 1'b0;
    case (instr[6:0])
      OP_IMM:            auto_fmt = (instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR:  auto_fmt = FMT_I;
      OP_STORE:          auto_fmt = FMT_S;
      OP_BRANCH:         auto_fmt = FMT_B;
      OP_LUI, OP_AUIPC:  auto_fmt = FMT_U;
      OP_JAL:            auto_fmt = FMT_J;
      OP_SYSTEM:         auto_fmt = instr[14] ? FMT_Z : FMT_I;
      OP_REG:            reg_op   = 1'b1;
      default:           auto_fmt = FMT_NONE;
    endcase
  end

  // Register-register ops carry no immediate but are still legal instructions.
  if (AUTO_SRC) begin : g_auto
    logic unused_src;
    assign sel_fmt    = auto_fmt;
    assign none_ok    = reg_op;
    assign unused_src = ^immsrc;
  end else begin : g_ext
    logic unused_dec;
    assign sel_fmt    = immsrc;
    assign none_ok    = 1'b0;
    assign unused_dec = ^{auto_fmt, reg_op};
  end

  always_comb begin
    imm32     = '0;
    sext      = 1'b1;
    field_bad = 1'b0;
    case (sel_fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z: begin
        sext  = 1'b0;
        imm32 = {27'b0, instr[19:15]};
      end
      FMT_SH: begin
        sext = 1'b0;
        if (XLEN == 64) begin
          imm32 = {26'b0, instr[25:20]};
        end else begin
          imm32     = {27'b0, instr[24:20]};
          field_bad = instr[25];
        end
      end
      default: begin
        sext      = 1'b0;
        field_bad = !none_ok;
      end
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm = {{32{sext & imm32[31]}}, imm32};
  end else begin : g_x32
    logic unused_sext;
    assign imm         = imm32;
    assign unused_sext = sext;
  end

  assign fmt     = sel_fmt;
  assign illegal = field_bad;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator behind a 2-entry skid buffer; 1-cycle latency when empty, 1/cycle throughput.
// Backpressure: in_ready (registered) drops once the skid entry fills; flush empties both entries.
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit AUTO_SRC = 1'b1,
  parameter int TAG_W    = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;
  logic             dec_ill;
  ent_t             new_ent;
  ent_t             main_q, main_d, skid_q, skid_d;
  logic             main_vld, main_vld_d, skid_vld, skid_vld_d;
  logic             rdy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc, drain;

  imm_fmt_comb #(.XLEN(XLEN), .AUTO_SRC(AUTO_SRC)) u_fmt (
    .instr   (in_instr),
    .immsrc  (in_immsrc),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign new_ent = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_ill, tag: in_tag};
  assign acc     = in_valid && rdy_q && !flush;
  assign drain   = main_vld && out_ready;

  // rdy_q is low whenever skid holds an entry, so acc and a skid refill never coincide.
  always_comb begin
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain) begin
      if (skid_vld) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = acc;
        if (acc) main_d = new_ent;
      end
    end else if (acc) begin
      if (main_vld) begin
        skid_vld_d = 1'b1;
        skid_d     = new_ent;
      end else begin
        main_vld_d = 1'b1;
        main_d     = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_vld <= main_vld_d;
      skid_vld <= skid_vld_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      rdy_q    <= !skid_vld_d;
      if (acc && new_ent.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: four instances (XLEN 32/64, 2-bit counter, external select) on one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_immsrc;

  always #5 clk = ~clk;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm, r32_out_tag;
  logic [2:0]  r32_out_fmt;
  logic [15:0] r32_cnt;

  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm;
  logic [31:0] r64_out_tag;
  logic [2:0]  r64_out_fmt;
  logic [15:0] r64_cnt;

  logic        rc2_in_ready, rc2_out_valid, rc2_out_illegal;
  logic [31:0] rc2_out_imm, rc2_out_tag;
  logic [2:0]  rc2_out_fmt;
  logic [1:0]  rc2_cnt;

  logic        rsel_in_ready, rsel_out_valid, rsel_out_illegal;
  logic [31:0] rsel_out_imm, rsel_out_tag;
  logic [2:0]  rsel_out_fmt;
  logic [15:0] rsel_cnt;

  imm_gen_pipe #(.XLEN(32), .AUTO_SRC(1'b1), .TAG_W(32), .CNT_W(16)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(r32_out_valid),
    .out_ready(out_ready), .out_imm(r32_out_imm), .out_fmt(r32_out_fmt),
    .out_illegal(r32_out_illegal), .out_tag(r32_out_tag), .illegal_cnt(r32_cnt));

  imm_gen_pipe #(.XLEN(64), .AUTO_SRC(1'b1), .TAG_W(32), .CNT_W(16)) d64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(r64_out_valid),
    .out_ready(out_ready), .out_imm(r64_out_imm), .out_fmt(r64_out_fmt),
    .out_illegal(r64_out_illegal), .out_tag(r64_out_tag), .illegal_cnt(r64_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_SRC(1'b1), .TAG_W(32), .CNT_W(2)) dc2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rc2_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(rc2_out_valid),
    .out_ready(out_ready), .out_imm(rc2_out_imm), .out_fmt(rc2_out_fmt),
    .out_illegal(rc2_out_illegal), .out_tag(rc2_out_tag), .illegal_cnt(rc2_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_SRC(1'b0), .TAG_W(32), .CNT_W(16)) dsel (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rsel_in_ready),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag), .out_valid(rsel_out_valid),
    .out_ready(out_ready), .out_imm(rsel_out_imm), .out_fmt(rsel_out_fmt),
    .out_illegal(rsel_out_illegal), .out_tag(rsel_out_tag), .illegal_cnt(rsel_cnt));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill32;
    logic        ill64;
    logic        illsel;
    logic [31:0] tag;
  } exp_t;

  vec_t        tbl [15];
  exp_t        sb[$];
  exp_t        cur;
  int          errs = 0;
  int          checks = 0;
  int          seq = 0;
  int          m32 = 0, m64 = 0, mc2 = 0, msel = 0;
  logic        prev_stall = 1'b0, prev_flush = 1'b0;
  logic [31:0] prev_imm, prev_tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input int idx);
    seq++;
    in_valid   = 1'b1;
    in_instr   = tbl[idx].instr;
    in_immsrc  = tbl[idx].fmt;
    in_tag     = 32'hA000_0000 + 32'(seq);
    cur.imm32  = tbl[idx].imm32;
    cur.imm64  = tbl[idx].imm64;
    cur.fmt    = tbl[idx].fmt;
    cur.ill32  = tbl[idx].ill32;
    cur.ill64  = tbl[idx].ill64;
    cur.illsel = (tbl[idx].fmt == 3'b111) ? 1'b1 : tbl[idx].ill32;
    cur.tag    = in_tag;
  endtask

  task automatic wait_acc(output int tries);
    logic done;
    done  = 1'b0;
    tries = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      tries++;
      if (r32_in_ready) done = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chk("accept_within_budget", 64'(done), 64'd1);
  endtask

  task automatic send(input int idx);
    int tries;
    drive(idx);
    wait_acc(tries);
  endtask

  task automatic drain_sb;
    for (int t = 0; t < 60 && sb.size() > 0; t++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: counter model, output compare, stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      m32 = 0; m64 = 0; mc2 = 0; msel = 0;
      prev_stall = 1'b0;
      prev_flush = 1'b0;
    end else begin
      chk("cnt32", 64'(r32_cnt), 64'(m32));
      chk("cnt64", 64'(r64_cnt), 64'(m64));
      chk("cnt_c2", 64'(rc2_cnt), 64'(mc2));
      chk("cnt_sel", 64'(rsel_cnt), 64'(msel));
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", 64'(r32_out_valid), 64'd1);
        chk("stall_imm", 64'(r32_out_imm), 64'(prev_imm));
        chk("stall_tag", 64'(r32_out_tag), 64'(prev_tag));
      end
      if (r32_out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_output: got tag %0h expected none", r32_out_tag);
        end else begin
          e = sb.pop_front();
          chk("imm32", 64'(r32_out_imm), 64'(e.imm32));
          chk("fmt32", 64'(r32_out_fmt), 64'(e.fmt));
          chk("ill32", 64'(r32_out_illegal), 64'(e.ill32));
          chk("tag32", 64'(r32_out_tag), 64'(e.tag));
          chk("vld64", 64'(r64_out_valid), 64'd1);
          chk("imm64", r64_out_imm, e.imm64);
          chk("fmt64", 64'(r64_out_fmt), 64'(e.fmt));
          chk("ill64", 64'(r64_out_illegal), 64'(e.ill64));
          chk("tag64", 64'(r64_out_tag), 64'(e.tag));
          chk("vld_c2", 64'(rc2_out_valid), 64'd1);
          chk("imm_c2", 64'(rc2_out_imm), 64'(e.imm32));
          chk("fmt_c2", 64'(rc2_out_fmt), 64'(e.fmt));
          chk("ill_c2", 64'(rc2_out_illegal), 64'(e.ill32));
          chk("tag_c2", 64'(rc2_out_tag), 64'(e.tag));
          chk("vld_sel", 64'(rsel_out_valid), 64'd1);
          chk("imm_sel", 64'(rsel_out_imm), 64'(e.imm32));
          chk("fmt_sel", 64'(rsel_out_fmt), 64'(e.fmt));
          chk("ill_sel", 64'(rsel_out_illegal), 64'(e.illsel));
          chk("tag_sel", 64'(rsel_out_tag), 64'(e.tag));
        end
      end
      if (in_valid && r32_in_ready && !flush) begin
        sb.push_back(cur);
        if (cur.ill32) m32++;
        if (cur.ill64) m64++;
        if (cur.ill32 && mc2 < 3) mc2++;
        if (cur.illsel) msel++;
      end
      if (flush) sb.delete();
      prev_stall = r32_out_valid && !out_ready;
      prev_flush = flush;
      prev_imm   = r32_out_imm;
      prev_tag   = r32_out_tag;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int tries;
    int sat_exp [5];
    logic [31:0] first_tag;
    logic [15:0] cnt_before;
    logic [1:0]  cnt_c2_before;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0; in_immsrc = '0;

    //               instr          fmt     imm32          imm64                   i32   i64
    tbl[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
    tbl[2]  = '{32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
    tbl[3]  = '{32'h02009093, 3'd6, 32'h00000000, 64'h0000000000000020, 1'b1, 1'b0};
    tbl[4]  = '{32'hFE20AC23, 3'd1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0};
    tbl[5]  = '{32'h0010006F, 3'd4, 32'h00000800, 64'h0000000000000800, 1'b0, 1'b0};
    tbl[6]  = '{32'hFFFFF06F, 3'd4, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0};
    tbl[7]  = '{32'hFFFFD073, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0, 1'b0};
    tbl[8]  = '{32'h30009073, 3'd0, 32'h00000300, 64'h0000000000000300, 1'b0, 1'b0};
    tbl[9]  = '{32'h002081B3, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b0, 1'b0};
    tbl[10] = '{32'h0000007F, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1, 1'b1};
    tbl[11] = '{32'h4050D093, 3'd6, 32'h00000005, 64'h0000000000000005, 1'b0, 1'b0};
    tbl[12] = '{32'h80012083, 3'd0, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, 1'b0};
    tbl[13] = '{32'h7FF08067, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0, 1'b0};
    tbl[14] = '{32'h12345297, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(r32_out_valid), 64'd0);
    chk("rst_out_imm", 64'(r32_out_imm), 64'd0);
    chk("rst_out_fmt", 64'(r32_out_fmt), 64'd0);
    chk("rst_out_illegal", 64'(r32_out_illegal), 64'd0);
    chk("rst_out_tag", 64'(r32_out_tag), 64'd0);
    chk("rst_cnt", 64'(r32_cnt), 64'd0);
    chk("rst_in_ready", 64'(r32_in_ready), 64'd0);
    chk("rst_imm64", r64_out_imm, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 64'(r32_in_ready), 64'd1);
    @(posedge clk); #1;

    // Table vectors back-to-back with the consumer always ready
    send(0);
    chk("latency_valid", 64'(r32_out_valid), 64'd1);
    chk("latency_imm", 64'(r32_out_imm), 64'hFFFFFFFF);
    for (int i = 1; i < 15; i++) begin
      drive(i);
      wait_acc(tries);
      chk("throughput_first_try", 64'(tries), 64'd1);
    end
    drain_sb();
    chk("table_cnt32", 64'(r32_cnt), 64'd2);
    chk("table_cnt64", 64'(r64_cnt), 64'd1);
    chk("table_cnt_sel", 64'(rsel_cnt), 64'd3);
    chk("table_cnt_c2", 64'(rc2_cnt), 64'd2);

    // Backpressure: two accepts fill main and skid, third waits
    @(posedge clk); #1 out_ready = 1'b0;
    send(1);
    first_tag = in_tag;
    send(2);
    drive(4);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready32", 64'(r32_in_ready), 64'd0);
      chk("bp_in_ready64", 64'(r64_in_ready), 64'd0);
      chk("bp_in_ready_c2", 64'(rc2_in_ready), 64'd0);
      chk("bp_in_ready_sel", 64'(rsel_in_ready), 64'd0);
      chk("bp_head_tag", 64'(r32_out_tag), 64'(first_tag));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_acc(tries);
    drain_sb();

    // Flush with both entries full and an illegal word offered
    @(posedge clk); #1 out_ready = 1'b0;
    send(5);
    send(6);
    cnt_before    = r32_cnt;
    cnt_c2_before = rc2_cnt;
    drive(10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(r32_out_valid), 64'd0);
    chk("flush_in_ready", 64'(r32_in_ready), 64'd1);
    chk("flush_cnt32", 64'(r32_cnt), 64'(cnt_before));
    chk("flush_cnt_c2", 64'(rc2_cnt), 64'(cnt_c2_before));
    @(posedge clk); #1 out_ready = 1'b1;
    send(11);
    drain_sb();

    // Reset in the middle of a stalled stream
    @(posedge clk); #1 out_ready = 1'b0;
    send(7);
    send(8);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(r32_out_valid), 64'd0);
    chk("midrst_out_imm", 64'(r32_out_imm), 64'd0);
    chk("midrst_out_fmt", 64'(r32_out_fmt), 64'd0);
    chk("midrst_out_tag", 64'(r32_out_tag), 64'd0);
    chk("midrst_cnt", 64'(r32_cnt), 64'd0);
    chk("midrst_in_ready", 64'(r32_in_ready), 64'd0);
    chk("midrst_out_valid64", 64'(r64_out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_midrst", 64'(r32_in_ready), 64'd1);
    @(posedge clk); #1;

    // Saturating 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send(10);
      chk("sat_cnt_c2", 64'(rc2_cnt), 64'(sat_exp[i]));
      chk("sat_cnt32", 64'(r32_cnt), 64'(i + 1));
    end
    drain_sb();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
